// File: rtl/u712_pkg.sv
// Shared definitions for the U712 CPU-side bus logic: FSM encoding and 68040
// cycle decode constants.
package u712_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACK  = 3'd3,
    ST_ERR  = 3'd4
  } u712_state_e;

  localparam logic [1:0] TT_NORMAL = 2'b00;
  localparam logic [1:0] SIZ_LINE  = 2'b11;

  // Chip RAM lives where the top CHIP_TOP_BITS_DEF address bits are all zero.
  localparam int CHIP_TOP_BITS_DEF = 11;

endpackage

// File: rtl/u712_bus_timeout.sv
// Per-beat watchdog counter in the falling-edge CLK80 domain; expired_o is high
// once TIMEOUT_CLKS-1 enabled clocks have been counted since the last clear.
module u712_bus_timeout #(
  parameter int TIMEOUT_CLKS = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/u712_cpu_chip_bus.sv
// 68040 front end for the chip RAM controller: decodes chip RAM cycles, splits
// line transfers into four longword beats and acknowledges or times out each.
module u712_cpu_chip_bus
  import u712_pkg::*;
#(
  parameter int TIMEOUT_CLKS  = 255,
  parameter int CHIP_TOP_BITS = CHIP_TOP_BITS_DEF
) (
  input  logic        CLK80,
  input  logic        RESETn,
  input  logic        TSn,
  input  logic        RnW,
  input  logic [1:0]  TT,
  input  logic [1:0]  SIZ,
  input  logic [31:2] A,
  input  logic        CPU_TACK,
  output logic        RAM_TSn,
  output logic        RAMSPACEn,
  output logic [1:0]  RAM_A,
  output logic        RAM_RnW,
  output logic        TAn,
  output logic        TBIn,
  output logic        TEAn,
  output logic        BUSY,
  output u712_state_e STATE_DBG
);

  // Handshake: a one-clock RAM_TSn low is the request for one longword beat;
  // the controller answers with CPU_TACK high, honoured only while in WAIT.
  u712_state_e state_q, state_d;
  logic [1:0]  ram_a_q, ram_a_d;
  logic [1:0]  beats_q, beats_d;
  logic        ram_rnw_q, ram_rnw_d;
  logic        accept, expired, tmr_en;
  logic        unused_addr;

  assign accept = !TSn && (TT == TT_NORMAL) && (A[31 -: CHIP_TOP_BITS] == '0);
  assign unused_addr = ^A[31-CHIP_TOP_BITS:4];

  // The timer runs from the request strobe so expiry lands TIMEOUT_CLKS after it.
  assign tmr_en = (state_q == ST_REQ) || (state_q == ST_WAIT);

  u712_bus_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk_i    (CLK80),
    .rst_n_i  (RESETn),
    .clear_i  (!tmr_en),
    .en_i     (tmr_en),
    .expired_o(expired)
  );

  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= ST_IDLE;
      ram_a_q   <= 2'd0;
      beats_q   <= 2'd0;
      ram_rnw_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ram_a_q   <= ram_a_d;
      beats_q   <= beats_d;
      ram_rnw_q <= ram_rnw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ram_a_d   = ram_a_q;
    beats_d   = beats_q;
    ram_rnw_d = ram_rnw_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_REQ;
          ram_a_d   = A[3:2];
          ram_rnw_d = RnW;
          beats_d   = (SIZ == SIZ_LINE) ? 2'd3 : 2'd0;
        end
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        // An acknowledge on the expiry clock still completes the beat.
        if (CPU_TACK) begin
          state_d = ST_ACK;
        end else if (expired) begin
          state_d = ST_ERR;
        end
      end
      ST_ACK: begin
        if (beats_q != 2'd0) begin
          state_d = ST_REQ;
          ram_a_d = ram_a_q + 2'd1;
          beats_d = beats_q - 2'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    RAM_TSn   = 1'b1;
    TAn       = 1'b1;
    TEAn      = 1'b1;
    BUSY      = (state_q != ST_IDLE);
    RAMSPACEn = (state_q == ST_IDLE);
    unique case (state_q)
      ST_REQ:  RAM_TSn = 1'b0;
      ST_ACK:  TAn     = 1'b0;
      ST_ERR:  TEAn    = 1'b0;
      default: ;
    endcase
  end

  assign RAM_A     = ram_a_q;
  assign RAM_RnW   = ram_rnw_q;
  assign TBIn      = 1'b1;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_u712_cpu_chip_bus.sv
// Bench for u712_cpu_chip_bus: directed 68040 cycles, a controller responder
// driven from a per-beat delay table, and a scoreboard of expected bus events.
`timescale 1ns/1ps
module tb_u712_cpu_chip_bus;
  import u712_pkg::*;

  localparam int T = 255;
  localparam int W = 14;
  localparam logic [1:0] K_REQ = 2'd1;
  localparam logic [1:0] K_TA  = 2'd2;
  localparam logic [1:0] K_TEA = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        TSn, RnW, CPU_TACK;
  logic [1:0]  TT, SIZ;
  logic [31:2] A;
  logic        RAM_TSn, RAMSPACEn, RAM_RnW, TAn, TBIn, TEAn, BUSY;
  logic [1:0]  RAM_A;
  u712_state_e state_dbg;

  logic [W-1:0] exp_q[$];
  int ts_q[$];
  int rsp_d_q[$];
  int rsp_h_q[$];
  int cyc = 0;
  int last_ts = 0;
  int ts_total = 0;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  u712_cpu_chip_bus #(.TIMEOUT_CLKS(T)) dut (
    .CLK80(clk), .RESETn(rst_n), .TSn(TSn), .RnW(RnW), .TT(TT), .SIZ(SIZ),
    .A(A), .CPU_TACK(CPU_TACK), .RAM_TSn(RAM_TSn), .RAMSPACEn(RAMSPACEn),
    .RAM_A(RAM_A), .RAM_RnW(RAM_RnW), .TAn(TAn), .TBIn(TBIn), .TEAn(TEAn),
    .BUSY(BUSY), .STATE_DBG(state_dbg)
  );

  function automatic logic [W-1:0] ev(input logic [1:0] k, input logic [1:0] a,
                                      input logic r, input int d);
    return {k, a, r, 9'(d)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input string name, input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: got unexpected event %0h expected none (cycle %0d)", name, got, cyc);
    end else begin
      chk(name, 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  // Monitor: every strobe/acknowledge the DUT presents is matched to the queue.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (!RAM_TSn) begin
        last_ts = cyc;
        ts_total++;
        ts_q.push_back(cyc);
        observe("req", ev(K_REQ, RAM_A, RAM_RnW, 0));
        chk("tbin", 32'(TBIn), 32'd1);
      end
      if (!TAn) begin
        observe("ta", ev(K_TA, RAM_A, RAM_RnW, cyc - last_ts));
        chk("ta_tea_excl", 32'(TEAn), 32'd1);
      end
      if (!TEAn) begin
        observe("tea", ev(K_TEA, RAM_A, RAM_RnW, cyc - last_ts));
        chk("tea_ta_excl", 32'(TAn), 32'd1);
      end
    end
  end

  // Controller model: raise CPU_TACK d clocks after each strobe for h clocks; d<0 never answers.
  initial begin
    int t, d, h;
    CPU_TACK = 1'b0;
    forever begin
      @(posedge clk);
      if (ts_q.size() != 0 && rsp_d_q.size() != 0) begin
        t = ts_q.pop_front();
        d = rsp_d_q.pop_front();
        h = rsp_h_q.pop_front();
        if (d > 0) begin
          while (cyc < t + d) @(posedge clk);
          CPU_TACK = 1'b1;
          repeat (h) @(posedge clk);
          CPU_TACK = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic rnw, input logic [1:0] tt,
                       input logic [1:0] siz);
    @(posedge clk);
    TSn = 1'b0; A = addr[31:2]; RnW = rnw; TT = tt; SIZ = siz;
    @(posedge clk);
    TSn = 1'b1; A = '0; RnW = 1'b1; TT = 2'b00; SIZ = 2'b00;
  endtask

  task automatic plan_beat(input logic [1:0] a, input logic rnw, input int d, input int h);
    exp_q.push_back(ev(K_REQ, a, rnw, 0));
    exp_q.push_back(ev(K_TA, a, rnw, d + 1));
    rsp_d_q.push_back(d);
    rsp_h_q.push_back(h);
  endtask

  task automatic flush();
    exp_q.delete();
    ts_q.delete();
    rsp_d_q.delete();
    rsp_h_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((BUSY || exp_q.size() != 0) && n < 1000);
    if (BUSY || exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s: busy=%0d pending=%0d expected idle within 1000 cycles", name, BUSY, exp_q.size());
    end else begin
      chk({name, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    end
    flush();
  endtask

  task automatic watch_ignored(input string name);
    logic seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      if (BUSY || !RAMSPACEn) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {23'd0, RAM_TSn, RAMSPACEn, RAM_A, RAM_RnW, TAn, TBIn, TEAn, BUSY},
        32'b1_1_00_1_1_1_1_0);
    chk({name, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n, start;
    rst_n = 1'b0; TSn = 1'b1; RnW = 1'b1; TT = 2'b00; SIZ = 2'b00; A = '0;
    repeat (3) @(posedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single longword read, acknowledge 8 clocks after the strobe.
    plan_beat(2'd0, 1'b1, 8, 1);
    issue(32'h0000_1000, 1'b1, 2'b00, 2'b00);
    n = 0;
    while (TAn && n < 200) begin @(posedge clk); n++; end
    @(posedge clk);
    chk("busy_after_ta", {30'd0, BUSY, RAMSPACEn}, 32'b01);
    wait_idle("single");

    // Line write from index 2 with a valid TSn during the line that must be ignored.
    plan_beat(2'd2, 1'b0, 1, 1);
    plan_beat(2'd3, 1'b0, 4, 1);
    plan_beat(2'd0, 1'b0, 2, 1);
    plan_beat(2'd1, 1'b0, 6, 1);
    issue(32'h0000_0008, 1'b0, 2'b00, 2'b11);
    repeat (4) @(posedge clk);
    issue(32'h0000_0000, 1'b1, 2'b00, 2'b00);
    wait_idle("line_wr");

    issue(32'h0020_0000, 1'b1, 2'b00, 2'b00);
    watch_ignored("ignore_addr");
    issue(32'h0000_0000, 1'b1, 2'b01, 2'b00);
    watch_ignored("ignore_tt");
    flush();

    // No acknowledge: error terminate exactly T clocks after the strobe.
    exp_q.push_back(ev(K_REQ, 2'd1, 1'b1, 0));
    exp_q.push_back(ev(K_TEA, 2'd1, 1'b1, T));
    rsp_d_q.push_back(-1);
    rsp_h_q.push_back(0);
    issue(32'h0000_0004, 1'b1, 2'b00, 2'b00);
    wait_idle("timeout");

    // Line read from index 3, first acknowledge held three clocks.
    plan_beat(2'd3, 1'b1, 2, 3);
    plan_beat(2'd0, 1'b1, 2, 1);
    plan_beat(2'd1, 1'b1, 2, 1);
    plan_beat(2'd2, 1'b1, 2, 1);
    issue(32'h0000_000C, 1'b1, 2'b00, 2'b11);
    wait_idle("hold_tack");

    // Reset pulsed while the second beat of a line is outstanding.
    plan_beat(2'd0, 1'b1, 3, 1);
    exp_q.push_back(ev(K_REQ, 2'd1, 1'b1, 0));
    rsp_d_q.push_back(-1);
    rsp_h_q.push_back(0);
    start = ts_total;
    issue(32'h0000_0000, 1'b1, 2'b00, 2'b11);
    n = 0;
    while (ts_total < start + 2 && n < 200) begin @(posedge clk); n++; end
    chk("rst_beat2_seen", 32'(ts_total - start), 32'd2);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid_reset");
    chk("rst_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    flush();
    repeat (2) @(posedge clk);
    plan_beat(2'd0, 1'b1, 3, 1);
    issue(32'h0000_0000, 1'b1, 2'b00, 2'b00);
    wait_idle("after_reset");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
